// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types, encodings and helpers for the hazard controller
//
// Package hazard_pkg:
//   FWD_GRF/FWD_E/FWD_M/FWD_W  D-stage forwarding select encodings
//   TUSE_NONE                  Tuse value meaning "operand not read"
//   sb_entry_t                 scoreboard entry {addr, tnew, md}
//   hz_res_t                   per-operand hazard result {stall, sel}
//   MULT_CYC_DEFAULT/DIV_CYC_DEFAULT  default mult/div busy latencies
package hazard_pkg;

    localparam logic [1:0] FWD_GRF = 2'b00;
    localparam logic [1:0] FWD_E   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;
    localparam logic [1:0] FWD_W   = 2'b11;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYC_DEFAULT = 5;
    localparam int DIV_CYC_DEFAULT  = 10;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] tnew;
        logic       md;
    } sb_entry_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] sel;
    } hz_res_t;

    // Age an entry by one stage; tnew saturates at 0 once the value exists.
    function automatic sb_entry_t age_entry(input sb_entry_t e);
        sb_entry_t r;
        r = e;
        if (e.tnew != 2'd0) begin
            r.tnew = e.tnew - 2'd1;
        end
        return r;
    endfunction

    // Youngest matching stage decides both stall and forward select.
    // A match that is not ready yet forwards nothing here; the consumer
    // either stalls or picks the value up from a later-stage mux.
    function automatic hz_res_t resolve(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input sb_entry_t  e,
        input sb_entry_t  m,
        input sb_entry_t  w
    );
        hz_res_t    r;
        logic       hit;
        logic [1:0] tnew;
        logic [1:0] code;
        r    = '0;
        hit  = 1'b0;
        tnew = 2'd0;
        code = FWD_GRF;
        if (src != 5'd0) begin
            if (e.addr == src) begin
                hit = 1'b1; tnew = e.tnew; code = FWD_E;
            end else if (m.addr == src) begin
                hit = 1'b1; tnew = m.tnew; code = FWD_M;
            end else if (w.addr == src) begin
                hit = 1'b1; tnew = w.tnew; code = FWD_W;
            end
        end
        if (hit) begin
            r.stall = (tnew > tuse);
            r.sel   = (tnew == 2'd0) ? code : FWD_GRF;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - D-stage hazard request/response bundle
//
// Signals: Rs_D, Rt_D, Tuse_Rs_D, Tuse_Rt_D, Wr_Addr_D, Tnew_D, Md_Start_D,
//          Md_Div_D, Md_Use_D (pipeline -> controller);
//          Stall, Fwd_Rs_Sel, Fwd_Rt_Sel, Md_Busy, Stall_Count (controller -> pipeline)
// Modports: master = pipeline side, slave = hazard controller side.
interface hazard_ctrl_if;

    logic [4:0]  Rs_D;
    logic [4:0]  Rt_D;
    logic [1:0]  Tuse_Rs_D;
    logic [1:0]  Tuse_Rt_D;
    logic [4:0]  Wr_Addr_D;
    logic [1:0]  Tnew_D;
    logic        Md_Start_D;
    logic        Md_Div_D;
    logic        Md_Use_D;

    logic        Stall;
    logic [1:0]  Fwd_Rs_Sel;
    logic [1:0]  Fwd_Rt_Sel;
    logic        Md_Busy;
    logic [31:0] Stall_Count;

    modport master (
        output Rs_D, Rt_D, Tuse_Rs_D, Tuse_Rt_D, Wr_Addr_D, Tnew_D,
               Md_Start_D, Md_Div_D, Md_Use_D,
        input  Stall, Fwd_Rs_Sel, Fwd_Rt_Sel, Md_Busy, Stall_Count
    );

    modport slave (
        input  Rs_D, Rt_D, Tuse_Rs_D, Tuse_Rt_D, Wr_Addr_D, Tnew_D,
               Md_Start_D, Md_Div_D, Md_Use_D,
        output Stall, Fwd_Rs_Sel, Fwd_Rt_Sel, Md_Busy, Stall_Count
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// rtl/hazard_ctrl_md_busy_counter.sv - mult/div busy counter
//
// Ports: Clk, Reset (async, active-high), load (mult/div in E), div (latency
//        select registered with it), busy (counter != 0).
// State updates on negedge Clk to line up with the pipeline registers.
module md_busy_counter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    input  logic div,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;

    // A load always overwrites, even if a previous operation is still running.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller for the 5-stage MIPS core
//
// Ports: Clk (state on negedge), Reset (async, active-high),
//        hz (hazard_ctrl_if.slave): D-stage operand/destination info in,
//        Stall / Fwd_Rs_Sel / Fwd_Rt_Sel / Md_Busy / Stall_Count out.
// Optional: define HAZARD_STATS_EN to build the 32-bit stall counter;
//           otherwise Stall_Count is tied to 0.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEFAULT,
    parameter int DIV_CYC  = DIV_CYC_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    hazard_ctrl_if.slave  hz
);

    sb_entry_t e_q, m_q, w_q;
    logic      e_div_q;
    logic      md_busy;
    hz_res_t   rs_res, rt_res;
    logic      md_stall;
    logic      stall;

    // Scoreboard: a stall turns the entry entering E into a bubble.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            e_div_q <= 1'b0;
        end else begin
            m_q <= age_entry(e_q);
            w_q <= age_entry(m_q);
            if (stall) begin
                e_q     <= '0;
                e_div_q <= 1'b0;
            end else begin
                e_q     <= '{addr: hz.Wr_Addr_D, tnew: hz.Tnew_D, md: hz.Md_Start_D};
                e_div_q <= hz.Md_Div_D;
            end
        end
    end

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy (
        .Clk   (Clk),
        .Reset (Reset),
        .load  (e_q.md),
        .div   (e_div_q),
        .busy  (md_busy)
    );

    always_comb begin
        rs_res   = resolve(hz.Rs_D, hz.Tuse_Rs_D, e_q, m_q, w_q);
        rt_res   = resolve(hz.Rt_D, hz.Tuse_Rt_D, e_q, m_q, w_q);
        // E.md covers the cycle before the counter has been loaded.
        md_stall = hz.Md_Use_D & (md_busy | e_q.md);
        stall    = rs_res.stall | rt_res.stall | md_stall;
    end

    assign hz.Stall      = stall;
    assign hz.Fwd_Rs_Sel = rs_res.sel;
    assign hz.Fwd_Rt_Sel = rt_res.sel;
    assign hz.Md_Busy    = md_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign hz.Stall_Count = stall_cnt_q;
`else
    assign hz.Stall_Count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic Clk   = 1'b1;
    logic Reset = 1'b1;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .hz    (hz)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    function automatic logic [31:0] exp_cnt(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a D-stage instruction and let the combinational outputs settle.
    task automatic drive(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [1:0] tuse_rs, input logic [1:0] tuse_rt,
        input logic [4:0] wr, input logic [1:0] tnew,
        input logic md_start, input logic md_div, input logic md_use
    );
        hz.Rs_D       = rs;
        hz.Rt_D       = rt;
        hz.Tuse_Rs_D  = tuse_rs;
        hz.Tuse_Rt_D  = tuse_rt;
        hz.Wr_Addr_D  = wr;
        hz.Tnew_D     = tnew;
        hz.Md_Start_D = md_start;
        hz.Md_Div_D   = md_div;
        hz.Md_Use_D   = md_use;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next();
        @(negedge Clk);
        #2;
    endtask

    initial begin
        idle();
        #11;
        check("reset_stall", 32'(hz.Stall), 32'd0);
        check("reset_fwd_rs", 32'(hz.Fwd_Rs_Sel), 32'd0);
        check("reset_fwd_rt", 32'(hz.Fwd_Rt_Sel), 32'd0);
        check("reset_busy", 32'(hz.Md_Busy), 32'd0);
        check("reset_count", hz.Stall_Count, 32'd0);
        Reset = 1'b0;
        next();

        // lw $1 (Tnew 2) then beq on $1 (Tuse 0)
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        check("lw_issue_stall", 32'(hz.Stall), 32'd0);
        next();
        drive(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("beq_stall_e", 32'(hz.Stall), 32'd1);
        check("beq_fwd_e", 32'(hz.Fwd_Rs_Sel), 32'd0);
        next();
        check("beq_stall_m", 32'(hz.Stall), 32'd1);
        check("beq_fwd_m", 32'(hz.Fwd_Rs_Sel), 32'd0);
        next();
        check("beq_go", 32'(hz.Stall), 32'd0);
        check("beq_fwd_w", 32'(hz.Fwd_Rs_Sel), 32'd3);
        check("count_after_lw", hz.Stall_Count, exp_cnt(2));
        next();

        // addu $2 (Tnew 1) then rt reader with Tuse 1
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        next();
        drive(5'd0, 5'd2, 2'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("addu_e_stall", 32'(hz.Stall), 32'd0);
        check("addu_e_fwd_rt", 32'(hz.Fwd_Rt_Sel), 32'd0);
        next();
        check("addu_m_stall", 32'(hz.Stall), 32'd0);
        check("addu_m_fwd_rt", 32'(hz.Fwd_Rt_Sel), 32'd2);
        check("addu_m_fwd_rs", 32'(hz.Fwd_Rs_Sel), 32'd0);
        next();

        // $3 in W (tnew 0) and E (tnew 1): E wins
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        next();
        idle();
        next();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        check("y_issue_stall", 32'(hz.Stall), 32'd0);
        next();
        drive(5'd3, 5'd3, 2'd1, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("young_stall", 32'(hz.Stall), 32'd0);
        check("young_fwd_rs", 32'(hz.Fwd_Rs_Sel), 32'd0);
        check("young_fwd_rt", 32'(hz.Fwd_Rt_Sel), 32'd0);
        next();

        // register 0 never matches
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        next();
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("r0_stall", 32'(hz.Stall), 32'd0);
        check("r0_fwd_rs", 32'(hz.Fwd_Rs_Sel), 32'd0);
        check("r0_fwd_rt", 32'(hz.Fwd_Rt_Sel), 32'd0);
        next();

        // div then mflo
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        check("div_issue_stall", 32'(hz.Stall), 32'd0);
        next();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1);
        check("div_e_stall", 32'(hz.Stall), 32'd1);
        check("div_e_busy", 32'(hz.Md_Busy), 32'd0);
        next();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("div_busy_%0d", i), 32'(hz.Md_Busy), 32'd1);
            check($sformatf("div_stall_%0d", i), 32'(hz.Stall), 32'd1);
            next();
        end
        check("div_done_busy", 32'(hz.Md_Busy), 32'd0);
        check("div_done_stall", 32'(hz.Stall), 32'd0);
        next();

        // mult then mflo
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        check("mult_issue_stall", 32'(hz.Stall), 32'd0);
        next();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b1);
        check("mult_e_stall", 32'(hz.Stall), 32'd1);
        next();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mult_busy_%0d", i), 32'(hz.Md_Busy), 32'd1);
            check($sformatf("mult_stall_%0d", i), 32'(hz.Stall), 32'd1);
            next();
        end
        check("mult_done_busy", 32'(hz.Md_Busy), 32'd0);
        check("mult_done_stall", 32'(hz.Stall), 32'd0);
        next();
        idle();
        next();

        // async reset while a lw stall and a mult are pending
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        next();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        next();
        drive(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_stall", 32'(hz.Stall), 32'd1);
        check("pre_rst_busy", 32'(hz.Md_Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check("rst_stall", 32'(hz.Stall), 32'd0);
        check("rst_busy", 32'(hz.Md_Busy), 32'd0);
        check("rst_fwd_rs", 32'(hz.Fwd_Rs_Sel), 32'd0);
        check("rst_count", hz.Stall_Count, 32'd0);
        drive(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        check("rst_any_stall", 32'(hz.Stall), 32'd0);
        next();
        Reset = 1'b0;
        #1;
        check("post_rst_stall", 32'(hz.Stall), 32'd0);
        check("post_rst_fwd_rt", 32'(hz.Fwd_Rt_Sel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Keeps a 3-entry scoreboard (E, M, W) of in-flight destination registers and their Tnew, compares it against the D-stage Tuse values, and drives the Pause of the D/E pipeline register, the PC/F-D freeze, and the D-stage forwarding selects.
- Also sequences the multi-cycle mult/div unit with a busy counter and stalls HI/LO consumers.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu
- DIV_CYC, 10, busy cycles for div/divu
- CNT_W, 4, busy counter width; must hold DIV_CYC

Ports:
- Clk  in  1  clock; all state updates on negedge Clk, matching the pipeline registers
- Reset  in  1  asynchronous, active-high; clears all state
- Rs_D  in  5  D-stage rs index
- Rt_D  in  5  D-stage rt index
- Tuse_Rs_D  in  2  cycles until rs is needed; 3 = not used
- Tuse_Rt_D  in  2  cycles until rt is needed; 3 = not used
- Wr_Addr_D  in  5  destination register of the D instruction; 0 = none
- Tnew_D  in  2  cycles after entering E until the result is ready
- Md_Start_D  in  1  D instruction starts mult/div
- Md_Div_D  in  1  1 = div latency, 0 = mult latency
- Md_Use_D  in  1  D instruction reads/writes HI/LO (mfhi, mflo, mthi, mtlo, mult, div)
- Stall  out  1  freeze PC and F/D; drives DEReg Pause, which inserts a bubble
- Fwd_Rs_Sel  out  2  00 = GRF, 01 = E, 10 = M, 11 = W
- Fwd_Rt_Sel  out  2  same encoding as Fwd_Rs_Sel
- Md_Busy  out  1  mult/div unit busy
- Stall_Count  out  32  stall statistics; see Optional Feature

Behaviour:
- Scoreboard entry = {addr[4:0], tnew[1:0], md}. Reset value of every entry: 0.
- Each negedge:
  - M <= E and W <= M, with tnew decremented and saturating at 0.
  - E <= {Wr_Addr_D, Tnew_D, Md_Start_D} when Stall = 0; E <= 0 (bubble) when Stall = 1.
- Match rule for rs: a stage matches when entry.addr == Rs_D and Rs_D != 0. The youngest matching stage wins (E over M over W). rt uses the same rule.
- Rs stall: the youngest match has tnew > Tuse_Rs_D. Rt stall is defined the same way.
- Fwd_Rs_Sel:
  - Code of the youngest match when its tnew == 0.
  - 00 when there is no match, or when the match has tnew > 0 (the value is forwarded later, downstream).
  - Fwd_Rt_Sel is defined the same way.
- Md stall: Md_Use_D and (Md_Busy or E.md).
- Stall = rs stall | rt stall | md stall. Combinational, same cycle as the inputs.
- Busy counter:
  - When E.md = 1 at a negedge, load MULT_CYC or DIV_CYC. Md_Div_D is registered alongside E.md for this purpose.
  - Otherwise decrement while nonzero.
  - Md_Busy = (counter != 0).
  - A load while already busy cannot happen because of the md stall. If it does, the new value overwrites the counter.
- Outputs are combinational from the state and the D inputs. After Reset: Stall = 0, Fwd_* = 00, Md_Busy = 0, Stall_Count = 0.
- Reset mid-operation: the scoreboard and counter clear immediately (asynchronous), with no pending stall.
- Register 0 never matches. Tuse = 3 never stalls, because tnew ≤ 2.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: Stall_Count increments at each negedge where Stall = 1, wraps at 2^32, and is cleared by Reset.
- Undefined: no counter is built and Stall_Count is tied to 0.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_GRF/FWD_E/FWD_M/FWD_W encodings
  - the TUSE_NONE = 3 constant
  - the scoreboard entry typedef
  - MULT/DIV default latencies
- One sub-module, md_busy_counter: counter, load select and Md_Busy.

Test Plan:
- lw $1 (Tnew = 2), then beq using $1 (Tuse = 0) → Stall for 2 cycles, then Fwd_Rs_Sel = 11 (W) with Stall = 0.
- addu $2 (Tnew = 1), then addu reading rt = $2 (Tuse = 1) → no stall and Fwd_Rt_Sel = 00 in the first cycle. One cycle later the entry sits in M with tnew = 0: a D reader there gets Fwd = 10.
- Writes to $3 in E (tnew 1) and in W (tnew 0), D reads $3 with Tuse = 1 → E is the youngest match, so no stall and Fwd = 00, not 11.
- Rs_D = 0 with E.addr = 0 and Tnew = 2 → Stall = 0, Fwd = 00.
- div accepted, then mflo → Md_Busy high for 10 cycles after the load, and mflo stalls until Md_Busy falls. Repeat with mult for 5 cycles.
- Assert Reset asynchronously while the lw stall is pending → Stall drops immediately and all entries read 0. With HAZARD_STATS_EN, Stall_Count reads 0, then counts 2 after the first scenario.
